// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: turns M-stage load/store control into a held,
// byte-enabled word request on a valid/ready port and extends the returned load data.
module mem_access_stage #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  MemReadM,
   input  logic                  MemWriteM,
   input  logic [2:0]            Funct3M,
   input  logic [DATA_WIDTH-1:0] ALUResultM,
   input  logic [DATA_WIDTH-1:0] WriteDataM,
   output logic                  dmem_req,
   output logic                  dmem_we,
   output logic [DATA_WIDTH-1:0] dmem_addr,
   output logic [3:0]            dmem_be,
   output logic [DATA_WIDTH-1:0] dmem_wdata,
   input  logic                  dmem_ready,
   input  logic [DATA_WIDTH-1:0] dmem_rdata,
   output logic [DATA_WIDTH-1:0] ReadDataM,
   output logic                  StallM,
   output logic                  AccessFaultM
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

   state_e                state_q, state_d;
   logic                  req_q, req_d;
   logic                  we_q, we_d;
   logic [DATA_WIDTH-1:0] addr_q, addr_d;
   logic [3:0]            be_q, be_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [2:0]            f3_q, f3_d;
   logic [1:0]            off_q, off_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

   logic                  acc;
   logic                  illegal;
   logic                  fault;
   logic [3:0]            beNew;
   logic [DATA_WIDTH-1:0] wdNew;
   logic [7:0]            laneByte;
   logic [15:0]           laneHalf;
   logic [DATA_WIDTH-1:0] loadExt;

   assign acc     = MemReadM | MemWriteM;
   assign illegal = (MemReadM & MemWriteM)
                  | (Funct3M == 3'b011) | (Funct3M == 3'b110) | (Funct3M == 3'b111)
                  | (MemWriteM & Funct3M[2])
                  | ((Funct3M[1:0] == 2'b01) & ALUResultM[0])
                  | ((Funct3M[1:0] == 2'b10) & (ALUResultM[1:0] != 2'b00));
   assign fault        = acc & illegal;
   assign AccessFaultM = fault;

   // Lane placement of the incoming access; loads carry no write data.
   always_comb begin
      beNew = 4'b1111;
      wdNew = WriteDataM;
      case (Funct3M[1:0])
         2'b00: begin
            beNew = 4'b0001 << ALUResultM[1:0];
            wdNew = {4{WriteDataM[7:0]}};
         end
         2'b01: begin
            beNew = ALUResultM[1] ? 4'b1100 : 4'b0011;
            wdNew = {2{WriteDataM[15:0]}};
         end
         default: ;
      endcase
      if (!MemWriteM) wdNew = '0;
   end

   always_comb begin
      laneByte = dmem_rdata[7:0];
      case (off_q)
         2'd1:    laneByte = dmem_rdata[15:8];
         2'd2:    laneByte = dmem_rdata[23:16];
         2'd3:    laneByte = dmem_rdata[31:24];
         default: ;
      endcase
      laneHalf = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (f3_q)
         3'b000:  loadExt = {{24{laneByte[7]}}, laneByte};
         3'b100:  loadExt = {24'd0, laneByte};
         3'b001:  loadExt = {{16{laneHalf[15]}}, laneHalf};
         3'b101:  loadExt = {16'd0, laneHalf};
         default: loadExt = dmem_rdata;
      endcase
   end

   // DONE exists so the held instruction cannot re-issue while the pipeline advances.
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      f3_d    = f3_q;
      off_d   = off_q;
      rdata_d = rdata_q;
      StallM  = 1'b0;
      case (state_q)
         IDLE: begin
            if (acc && !fault) begin
               state_d = BUSY;
               req_d   = 1'b1;
               we_d    = MemWriteM;
               addr_d  = {ALUResultM[DATA_WIDTH-1:2], 2'b00};
               be_d    = beNew;
               wdata_d = wdNew;
               f3_d    = Funct3M;
               off_d   = ALUResultM[1:0];
               StallM  = 1'b1;
            end else if (fault) begin
               rdata_d = '0;
            end
         end
         BUSY: begin
            StallM = 1'b1;
            if (dmem_ready) begin
               state_d = DONE;
               req_d   = 1'b0;
               if (!we_q) rdata_d = loadExt;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         be_q    <= 4'b0000;
         wdata_q <= '0;
         f3_q    <= 3'b000;
         off_q   <= 2'b00;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         f3_q    <= f3_d;
         off_q   <= off_d;
         rdata_q <= rdata_d;
      end
   end

   assign dmem_req   = req_q;
   assign dmem_we    = we_q;
   assign dmem_addr  = addr_q;
   assign dmem_be    = be_q;
   assign dmem_wdata = wdata_q;
   assign ReadDataM  = rdata_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage: loads, stores, faults,
// delayed ready, reset during an outstanding request and a non-memory follower.
module tb_mem_access_stage;

   logic        clk;
   logic        reset;
   logic        MemReadM;
   logic        MemWriteM;
   logic [2:0]  Funct3M;
   logic [31:0] ALUResultM;
   logic [31:0] WriteDataM;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_ready;
   logic [31:0] dmem_rdata;
   logic [31:0] ReadDataM;
   logic        StallM;
   logic        AccessFaultM;

   int tests = 0;
   int fails = 0;

   mem_access_stage #(.DATA_WIDTH(32)) dut (
      .clk(clk), .reset(reset),
      .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
      .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
      .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
      .ReadDataM(ReadDataM), .StallM(StallM), .AccessFaultM(AccessFaultM)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Move to just after the next rising edge; inputs change here, checks follow #1 later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setInstr(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd);
      MemReadM   = rd;
      MemWriteM  = wr;
      Funct3M    = f3;
      ALUResultM = a;
      WriteDataM = wd;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      setInstr(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      dmem_ready = 1'b0;
      dmem_rdata = 32'h0;
      tick();
      tick();
      #1;
      tests++; if (dmem_req !== 1'b0) begin fails++; $display("[TB] FAIL rst_req: got %b want 0", dmem_req); end
      tests++; if (dmem_we !== 1'b0) begin fails++; $display("[TB] FAIL rst_we: got %b want 0", dmem_we); end
      tests++; if (dmem_addr !== 32'h0) begin fails++; $display("[TB] FAIL rst_addr: got %h want 0", dmem_addr); end
      tests++; if (dmem_be !== 4'b0000) begin fails++; $display("[TB] FAIL rst_be: got %b want 0000", dmem_be); end
      tests++; if (dmem_wdata !== 32'h0) begin fails++; $display("[TB] FAIL rst_wdata: got %h want 0", dmem_wdata); end
      tests++; if (ReadDataM !== 32'h0) begin fails++; $display("[TB] FAIL rst_rdata: got %h want 0", ReadDataM); end
      tests++; if (StallM !== 1'b0) begin fails++; $display("[TB] FAIL rst_stall: got %b want 0", StallM); end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_lw();
      setInstr(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
      #1;
      tests++; if (StallM !== 1'b1) begin fails++; $display("[TB] FAIL lw_stall_c0: got %b want 1", StallM); end
      tests++; if (dmem_req !== 1'b0) begin fails++; $display("[TB] FAIL lw_req_c0: got %b want 0", dmem_req); end
      tests++; if (AccessFaultM !== 1'b0) begin fails++; $display("[TB] FAIL lw_fault: got %b want 0", AccessFaultM); end
      tick();
      dmem_ready = 1'b1;
      dmem_rdata = 32'hDEADBEEF;
      #1;
      tests++; if (dmem_req !== 1'b1) begin fails++; $display("[TB] FAIL lw_req_c1: got %b want 1", dmem_req); end
      tests++; if (dmem_addr !== 32'h100) begin fails++; $display("[TB] FAIL lw_addr: got %h want 00000100", dmem_addr); end
      tests++; if (dmem_be !== 4'b1111) begin fails++; $display("[TB] FAIL lw_be: got %b want 1111", dmem_be); end
      tests++; if (dmem_we !== 1'b0) begin fails++; $display("[TB] FAIL lw_we: got %b want 0", dmem_we); end
      tests++; if (StallM !== 1'b1) begin fails++; $display("[TB] FAIL lw_stall_c1: got %b want 1", StallM); end
      tick();
      dmem_ready = 1'b0;
      #1;
      tests++; if (dmem_req !== 1'b0) begin fails++; $display("[TB] FAIL lw_req_done: got %b want 0", dmem_req); end
      tests++; if (StallM !== 1'b0) begin fails++; $display("[TB] FAIL lw_stall_done: got %b want 0", StallM); end
      tests++; if (ReadDataM !== 32'hDEADBEEF) begin fails++; $display("[TB] FAIL lw_data: got %h want deadbeef", ReadDataM); end
      tick();
      setInstr(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      #1;
      tests++; if (dmem_req !== 1'b0) begin fails++; $display("[TB] FAIL lw_req_idle: got %b want 0", dmem_req); end
   endtask

   task automatic test_fault();
      setInstr(1'b1, 1'b0, 3'b010, 32'h102, 32'h0);
      #1;
      tests++; if (AccessFaultM !== 1'b1) begin fails++; $display("[TB] FAIL flt_lw_fault: got %b want 1", AccessFaultM); end
      tests++; if (StallM !== 1'b0) begin fails++; $display("[TB] FAIL flt_lw_stall: got %b want 0", StallM); end
      tick();
      #1;
      tests++; if (ReadDataM !== 32'h0) begin fails++; $display("[TB] FAIL flt_lw_rdata: got %h want 0", ReadDataM); end
      tests++; if (dmem_req !== 1'b0) begin fails++; $display("[TB] FAIL flt_lw_req: got %b want 0", dmem_req); end
      setInstr(1'b0, 1'b1, 3'b001, 32'h101, 32'h1234);
      #1;
      tests++; if (AccessFaultM !== 1'b1) begin fails++; $display("[TB] FAIL flt_sh_fault: got %b want 1", AccessFaultM); end
      tests++; if (StallM !== 1'b0) begin fails++; $display("[TB] FAIL flt_sh_stall: got %b want 0", StallM); end
      tick();
      #1;
      tests++; if (dmem_req !== 1'b0) begin fails++; $display("[TB] FAIL flt_sh_req: got %b want 0", dmem_req); end
      tests++; if (ReadDataM !== 32'h0) begin fails++; $display("[TB] FAIL flt_sh_rdata: got %h want 0", ReadDataM); end
      setInstr(1'b1, 1'b0, 3'b011, 32'h100, 32'h0);
      #1;
      tests++; if (AccessFaultM !== 1'b1) begin fails++; $display("[TB] FAIL flt_f3_fault: got %b want 1", AccessFaultM); end
      tick();
      setInstr(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      tick();
   endtask

   task automatic test_lb_lbu();
      setInstr(1'b1, 1'b0, 3'b000, 32'h203, 32'h0);
      dmem_rdata = 32'h80FF1234;
      #1;
      tests++; if (StallM !== 1'b1) begin fails++; $display("[TB] FAIL lb_stall: got %b want 1", StallM); end
      tick();
      dmem_ready = 1'b1;
      #1;
      tests++; if (dmem_be !== 4'b1000) begin fails++; $display("[TB] FAIL lb_be: got %b want 1000", dmem_be); end
      tests++; if (dmem_addr !== 32'h200) begin fails++; $display("[TB] FAIL lb_addr: got %h want 00000200", dmem_addr); end
      tick();
      dmem_ready = 1'b0;
      #1;
      tests++; if (ReadDataM !== 32'hFFFFFF80) begin fails++; $display("[TB] FAIL lb_data: got %h want ffffff80", ReadDataM); end
      tick();
      setInstr(1'b1, 1'b0, 3'b100, 32'h203, 32'h0);
      #1;
      tests++; if (StallM !== 1'b1) begin fails++; $display("[TB] FAIL lbu_stall: got %b want 1", StallM); end
      tick();
      dmem_ready = 1'b1;
      #1;
      tests++; if (dmem_be !== 4'b1000) begin fails++; $display("[TB] FAIL lbu_be: got %b want 1000", dmem_be); end
      tick();
      dmem_ready = 1'b0;
      #1;
      tests++; if (ReadDataM !== 32'h00000080) begin fails++; $display("[TB] FAIL lbu_data: got %h want 00000080", ReadDataM); end
      tick();
      setInstr(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
   endtask

   task automatic test_sh_delayed();
      int stallCount;
      tick();
      setInstr(1'b0, 1'b1, 3'b001, 32'h302, 32'h0000ABCD);
      dmem_rdata = 32'h11111111;
      dmem_ready = 1'b0;
      #1;
      stallCount = (StallM === 1'b1) ? 1 : 0;
      for (int c = 1; c <= 4; c++) begin
         tick();
         dmem_ready = (c == 4);
         #1;
         if (StallM === 1'b1) stallCount++;
         tests++; if (dmem_req !== 1'b1) begin fails++; $display("[TB] FAIL sh_req_c%0d: got %b want 1", c, dmem_req); end
         tests++; if (dmem_addr !== 32'h300) begin fails++; $display("[TB] FAIL sh_addr_c%0d: got %h want 00000300", c, dmem_addr); end
         tests++; if (dmem_be !== 4'b1100) begin fails++; $display("[TB] FAIL sh_be_c%0d: got %b want 1100", c, dmem_be); end
         tests++; if (dmem_wdata !== 32'hABCDABCD) begin fails++; $display("[TB] FAIL sh_wdata_c%0d: got %h want abcdabcd", c, dmem_wdata); end
         tests++; if (dmem_we !== 1'b1) begin fails++; $display("[TB] FAIL sh_we_c%0d: got %b want 1", c, dmem_we); end
      end
      tick();
      dmem_ready = 1'b0;
      #1;
      if (StallM === 1'b1) stallCount++;
      tests++; if (dmem_req !== 1'b0) begin fails++; $display("[TB] FAIL sh_req_done: got %b want 0", dmem_req); end
      tests++; if (ReadDataM !== 32'h00000080) begin fails++; $display("[TB] FAIL sh_rdata_kept: got %h want 00000080", ReadDataM); end
      tests++; if (stallCount !== 5) begin fails++; $display("[TB] FAIL sh_stall_cycles: got %0d want 5", stallCount); end
      tick();
      setInstr(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
   endtask

   task automatic test_back_to_back();
      tick();
      setInstr(1'b0, 1'b1, 3'b000, 32'h201, 32'h000000A5);
      #1;
      tests++; if (StallM !== 1'b1) begin fails++; $display("[TB] FAIL sb_stall: got %b want 1", StallM); end
      tick();
      dmem_ready = 1'b1;
      #1;
      tests++; if (dmem_be !== 4'b0010) begin fails++; $display("[TB] FAIL sb_be: got %b want 0010", dmem_be); end
      tests++; if (dmem_wdata !== 32'hA5A5A5A5) begin fails++; $display("[TB] FAIL sb_wdata: got %h want a5a5a5a5", dmem_wdata); end
      tick();
      #1;
      tests++; if (dmem_req !== 1'b0) begin fails++; $display("[TB] FAIL sb_req_done: got %b want 0", dmem_req); end
      tests++; if (StallM !== 1'b0) begin fails++; $display("[TB] FAIL sb_stall_done: got %b want 0", StallM); end
      tick();
      setInstr(1'b0, 1'b0, 3'b000, 32'h1234, 32'h0);
      #1;
      tests++; if (StallM !== 1'b0) begin fails++; $display("[TB] FAIL add_stall: got %b want 0", StallM); end
      tests++; if (dmem_req !== 1'b0) begin fails++; $display("[TB] FAIL add_req: got %b want 0", dmem_req); end
      tick();
      dmem_ready = 1'b0;
      #1;
      tests++; if (dmem_req !== 1'b0) begin fails++; $display("[TB] FAIL add_req_next: got %b want 0", dmem_req); end
      tests++; if (ReadDataM !== 32'h00000080) begin fails++; $display("[TB] FAIL add_rdata_kept: got %h want 00000080", ReadDataM); end
   endtask

   task automatic test_reset_busy();
      tick();
      setInstr(1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
      dmem_ready = 1'b0;
      tick();
      #1;
      tests++; if (dmem_req !== 1'b1) begin fails++; $display("[TB] FAIL rb_req_b1: got %b want 1", dmem_req); end
      tests++; if (dmem_addr !== 32'h40) begin fails++; $display("[TB] FAIL rb_addr: got %h want 00000040", dmem_addr); end
      tick();
      reset = 1'b0;
      #1;
      tests++; if (StallM !== 1'b1) begin fails++; $display("[TB] FAIL rb_stall_b2: got %b want 1", StallM); end
      tick();
      reset = 1'b1;
      setInstr(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      #1;
      tests++; if (dmem_req !== 1'b0) begin fails++; $display("[TB] FAIL rb_req_after: got %b want 0", dmem_req); end
      tests++; if (StallM !== 1'b0) begin fails++; $display("[TB] FAIL rb_stall_after: got %b want 0", StallM); end
      tests++; if (ReadDataM !== 32'h0) begin fails++; $display("[TB] FAIL rb_rdata_after: got %h want 0", ReadDataM); end
      tick();
      dmem_ready = 1'b1;
      dmem_rdata = 32'hCAFEF00D;
      tick();
      dmem_ready = 1'b0;
      #1;
      tests++; if (dmem_req !== 1'b0) begin fails++; $display("[TB] FAIL rb_req_late: got %b want 0", dmem_req); end
      tests++; if (ReadDataM !== 32'h0) begin fails++; $display("[TB] FAIL rb_rdata_late: got %h want 0", ReadDataM); end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_fault();
      test_lb_lbu();
      test_sh_delayed();
      test_back_to_back();
      test_reset_busy();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
